output_spike_counter: RTL and testbench

OUTPUT_SPIKE_COUNTER -- requirements
Module: output_spike_counter

---
 rtl/output_spike_counter.sv | 180 ++++++++++++++++++
 tb/tb_output_spike_counter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_spike_counter.sv
// Counts layer-2 output spikes over a window of enable-edge samples; optional result FIFO via SPIKE_COUNTER_HISTORY_EN.
// Latency: counts, winner and result_valid appear one cycle after the closing sample.
// Backpressure: none on the sample path; a full history FIFO drops new results and flags hist_overflow.
module output_spike_counter #(
  parameter int COUNT_W = 8
) (
  input  logic               system_clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         output_spikes,
  input  logic [7:0]         window_len,
  output logic [COUNT_W-1:0] count0_out,
  output logic [COUNT_W-1:0] count1_out,
  output logic [1:0]         winner,
  output logic               result_valid
`ifdef SPIKE_COUNTER_HISTORY_EN
  ,
  input  logic                 hist_pop,
  output logic [2*COUNT_W+1:0] hist_data,
  output logic                 hist_empty,
  output logic                 hist_full,
  output logic                 hist_overflow
`endif
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic               enable_q;
  logic [7:0]         len_q;
  logic [7:0]         smp_cnt;
  logic [COUNT_W-1:0] cnt0;
  logic [COUNT_W-1:0] cnt1;

  logic               sample;
  logic [7:0]         smp_nxt;
  logic [COUNT_W-1:0] nxt0;
  logic [COUNT_W-1:0] nxt1;

  assign sample  = enable & ~enable_q;
  assign smp_nxt = smp_cnt + 8'd1;
  // Saturating accumulate: a full counter stays pinned at its maximum.
  assign nxt0 = (cnt0 == CNT_MAX) ? cnt0 : cnt0 + {{(COUNT_W-1){1'b0}}, output_spikes[0]};
  assign nxt1 = (cnt1 == CNT_MAX) ? cnt1 : cnt1 + {{(COUNT_W-1){1'b0}}, output_spikes[1]};

  always_ff @(posedge system_clock) begin
    if (!reset) begin
      state        <= IDLE;
      enable_q     <= 1'b1;
      len_q        <= '0;
      smp_cnt      <= '0;
      cnt0         <= '0;
      cnt1         <= '0;
      count0_out   <= '0;
      count1_out   <= '0;
      winner       <= 2'b00;
      result_valid <= 1'b0;
    end else begin
      enable_q     <= enable;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (window_len != 8'd0) begin
            len_q   <= window_len;
            smp_cnt <= '0;
            cnt0    <= '0;
            cnt1    <= '0;
            state   <= COUNT;
          end
        end
        COUNT: begin
          if (sample) begin
            if (smp_nxt == len_q) begin
              count0_out   <= nxt0;
              count1_out   <= nxt1;
              winner       <= (nxt0 > nxt1) ? 2'b01 : ((nxt1 > nxt0) ? 2'b10 : 2'b00);
              result_valid <= 1'b1;
              smp_cnt      <= '0;
              cnt0         <= '0;
              cnt1         <= '0;
              // window_len is only sampled at window boundaries.
              if (window_len != 8'd0) begin
                len_q <= window_len;
              end else begin
                state <= IDLE;
              end
            end else begin
              smp_cnt <= smp_nxt;
              cnt0    <= nxt0;
              cnt1    <= nxt1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPIKE_COUNTER_HISTORY_EN
  spike_hist_fifo #(
    .W     (2*COUNT_W+2),
    .DEPTH (4)
  ) u_hist (
    .clk      (system_clock),
    .rst_n    (reset),
    .push     (result_valid),
    .push_dat ({winner, count1_out, count0_out}),
    .pop      (hist_pop),
    .pop_dat  (hist_data),
    .empty    (hist_empty),
    .full     (hist_full),
    .overflow (hist_overflow)
  );
`endif

endmodule

`ifdef SPIKE_COUNTER_HISTORY_EN
// Generic show-ahead FIFO with synchronous active-low reset and sticky overflow flag.
// Latency: a pushed entry is visible at pop_dat the cycle after the push.
// Backpressure: push when full is dropped unless a pop happens in the same cycle.
module spike_hist_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Gate the head with empty so reset and drained states read as zero.
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule
`endif

// File: tb/tb_output_spike_counter.sv
// Randomized and directed bench for output_spike_counter against a window-level reference model.
module tb_output_spike_counter;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          system_clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    output_spikes = 2'b00;
  logic [7:0]    window_len = 8'd0;
  logic [CW-1:0] count0_out;
  logic [CW-1:0] count1_out;
  logic [1:0]    winner;
  logic          result_valid;
`ifdef SPIKE_COUNTER_HISTORY_EN
  logic            hist_pop = 1'b0;
  logic [2*CW+1:0] hist_data;
  logic            hist_empty;
  logic            hist_full;
  logic            hist_overflow;
`endif

  output_spike_counter #(.COUNT_W(CW)) dut (
    .system_clock  (system_clock),
    .reset         (reset),
    .enable        (enable),
    .output_spikes (output_spikes),
    .window_len    (window_len),
    .count0_out    (count0_out),
    .count1_out    (count1_out),
    .winner        (winner),
    .result_valid  (result_valid)
`ifdef SPIKE_COUNTER_HISTORY_EN
    ,
    .hist_pop      (hist_pop),
    .hist_data     (hist_data),
    .hist_empty    (hist_empty),
    .hist_full     (hist_full),
    .hist_overflow (hist_overflow)
`endif
  );

  always #5 system_clock = ~system_clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a window is a list of samples; results are totals clipped to CMAX.
  bit m_prev_en;
  bit m_open;
  int m_len, m_n, m_h0, m_h1;
  int e_c0, e_c1, e_win;
  bit e_rv;
  int hq[$];
  bit e_ovf;

  task automatic model_step();
    bit smp;
    int c0, c1;
    if (!reset) begin
      m_prev_en = 1; m_open = 0; m_n = 0; m_h0 = 0; m_h1 = 0;
      e_c0 = 0; e_c1 = 0; e_win = 0; e_rv = 0;
      hq.delete(); e_ovf = 0;
      return;
    end
`ifdef SPIKE_COUNTER_HISTORY_EN
    if (hist_pop && hq.size() > 0) void'(hq.pop_front());
    if (e_rv) begin
      if (hq.size() < 4) hq.push_back((e_win << (2*CW)) | (e_c1 << CW) | e_c0);
      else e_ovf = 1;
    end
`endif
    smp = enable && !m_prev_en;
    m_prev_en = enable;
    e_rv = 0;
    if (!m_open) begin
      if (window_len != 0) begin
        m_open = 1; m_len = window_len; m_n = 0; m_h0 = 0; m_h1 = 0;
      end
    end else if (smp) begin
      m_n++;
      m_h0 += output_spikes[0];
      m_h1 += output_spikes[1];
      if (m_n == m_len) begin
        c0 = (m_h0 > CMAX) ? CMAX : m_h0;
        c1 = (m_h1 > CMAX) ? CMAX : m_h1;
        e_c0 = c0; e_c1 = c1;
        e_win = (c0 > c1) ? 1 : ((c1 > c0) ? 2 : 0);
        e_rv = 1;
        m_n = 0; m_h0 = 0; m_h1 = 0;
        if (window_len != 0) m_len = window_len;
        else m_open = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge system_clock);
    #1;
    check("result_valid", result_valid, e_rv);
    check("count0_out", count0_out, e_c0);
    check("count1_out", count1_out, e_c1);
    check("winner", winner, e_win);
`ifdef SPIKE_COUNTER_HISTORY_EN
    check("hist_data", hist_data, (hq.size() > 0) ? hq[0] : 0);
    check("hist_empty", hist_empty, hq.size() == 0);
    check("hist_full", hist_full, hq.size() == 4);
    check("hist_overflow", hist_overflow, e_ovf);
`endif
  endtask

  task automatic pulse(input logic [1:0] sp);
    enable = 1'b1;
    output_spikes = sp;
    tick();
  endtask

  task automatic rest(input int n);
    enable = 1'b0;
    output_spikes = 2'($urandom);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  initial begin
    do_reset();
    check("reset_count0", count0_out, 0);
    check("reset_winner", winner, 0);

    // Basic window of four samples.
    window_len = 8'd4; tick();
    pulse(2'b01); rest(1); pulse(2'b11); rest(1); pulse(2'b01); rest(1);
    check("w4_not_yet", result_valid, 0);
    pulse(2'b00);
    check("w4_valid", result_valid, 1);
    check("w4_c0", count0_out, 3);
    check("w4_c1", count1_out, 1);
    check("w4_winner", winner, 2'b01);
    rest(1);
    check("w4_pulse_one_cycle", result_valid, 0);

    // Tie, then a fresh window starting from zero.
    do_reset();
    window_len = 8'd3; tick();
    pulse(2'b10); rest(1); pulse(2'b01); rest(1); pulse(2'b00);
    check("tie_valid", result_valid, 1);
    check("tie_c0", count0_out, 1);
    check("tie_c1", count1_out, 1);
    check("tie_winner", winner, 2'b00);
    rest(1); pulse(2'b01); rest(1); pulse(2'b00); rest(1); pulse(2'b00);
    check("fresh_c0", count0_out, 1);
    check("fresh_c1", count1_out, 0);
    check("fresh_winner", winner, 2'b01);

    // Saturation.
    do_reset();
    window_len = 8'd20; tick();
    for (int i = 0; i < 19; i++) begin pulse(2'b11); rest(1); end
    pulse(2'b11);
    check("sat_valid", result_valid, 1);
    check("sat_c0", count0_out, CMAX);
    check("sat_c1", count1_out, CMAX);
    check("sat_winner", winner, 2'b00);

    // window_len changes mid-window, then drops to zero.
    do_reset();
    window_len = 8'd4; tick();
    pulse(2'b01); rest(1); pulse(2'b01); rest(1);
    window_len = 8'd2;
    pulse(2'b01); rest(1);
    check("len_change_ignored", result_valid, 0);
    pulse(2'b01);
    check("len_old_close", result_valid, 1);
    check("len_old_c0", count0_out, 4);
    rest(1); pulse(2'b10);
    check("len_new_open", result_valid, 0);
    rest(1); pulse(2'b10);
    check("len_new_close", result_valid, 1);
    check("len_new_c1", count1_out, 2);
    rest(1); pulse(2'b00); rest(1);
    window_len = 8'd0;
    pulse(2'b11);
    check("len0_last_close", result_valid, 1);
    rest(1);
    for (int i = 0; i < 3; i++) begin
      pulse(2'b11);
      check("len0_idle_no_valid", result_valid, 0);
      rest(1);
    end
    check("len0_hold_c0", count0_out, 1);

    // Reset mid-window with enable held high across release.
    do_reset();
    window_len = 8'd4; tick();
    pulse(2'b01); rest(1); pulse(2'b01); rest(1); pulse(2'b01); rest(1);
    enable = 1'b1; reset = 1'b0; tick();
    reset = 1'b1;
    repeat (3) tick();
    check("rst_mid_no_valid", result_valid, 0);
    check("rst_mid_c0", count0_out, 0);
    rest(1);
    pulse(2'b01); rest(1); pulse(2'b01); rest(1); pulse(2'b01); rest(1);
    check("rst_held_not_counted", result_valid, 0);
    pulse(2'b01);
    check("rst_after_valid", result_valid, 1);
    check("rst_after_c0", count0_out, 4);

`ifdef SPIKE_COUNTER_HISTORY_EN
    begin
      logic [1:0] sps [5];
      int exp_h [4];
      sps = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
      exp_h = '{(1 << (2*CW)) | 1, (2 << (2*CW)) | (1 << CW), (1 << CW) | 1, 0};
      do_reset();
      hist_pop = 1'b0;
      window_len = 8'd1; tick();
      for (int k = 0; k < 5; k++) begin pulse(sps[k]); rest(2); end
      check("hist_full_after5", hist_full, 1);
      check("hist_ovf_after5", hist_overflow, 1);
      window_len = 8'd0; rest(1);
      for (int k = 0; k < 4; k++) begin
        check("hist_order", hist_data, exp_h[k]);
        hist_pop = 1'b1; tick(); hist_pop = 1'b0;
      end
      check("hist_empty_after4", hist_empty, 1);
      hist_pop = 1'b1; tick(); hist_pop = 1'b0;
      check("hist_pop_empty_data", hist_data, 0);
    end
`endif

    // Randomized phase.
    do_reset();
    window_len = 8'd3;
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        reset = 1'b0; enable = 1'($urandom); tick(); reset = 1'b1;
      end else if (r < 14) begin
        window_len = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
      end
`ifdef SPIKE_COUNTER_HISTORY_EN
      hist_pop = ($urandom_range(0, 3) == 0);
`endif
      pulse(2'($urandom));
      if ($urandom_range(0, 4) == 0) tick();
      rest($urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
